// File: rtl/audipus_rate_pkg.sv
// Shared types and widths for the audio rate-conversion path
// (receiver -> sample_phase_tracker -> interpolator).
package audipus_rate_pkg;

    localparam int SAMPLE_W = 24;
    localparam int PHASE_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOST    = 2'd3
    } track_state_t;

endpackage

// File: rtl/sample_phase_tracker_if.sv
// Sample bus between the I2S receiver, the phase tracker and the interpolator:
// raw receiver frames in, re-timed strobes with data and phase out.
interface sample_phase_tracker_if;
    import audipus_rate_pkg::*;

    logic                in_strobe;
    logic [SAMPLE_W-1:0] l_in;
    logic [SAMPLE_W-1:0] r_in;
    logic                l_din_en;
    logic                r_din_en;
    logic [SAMPLE_W-1:0] l_data_out;
    logic [SAMPLE_W-1:0] r_data_out;
    logic [PHASE_W-1:0]  sub_sample_cnt;

    modport master (
        output in_strobe, l_in, r_in,
        input  l_din_en, r_din_en, l_data_out, r_data_out, sub_sample_cnt
    );

    modport slave (
        input  in_strobe, l_in, r_in,
        output l_din_en, r_din_en, l_data_out, r_data_out, sub_sample_cnt
    );

endinterface

// File: rtl/strobe_period_counter.sv
// Measures cycles between accepted input strobes; holds the last valid period.
// A period is valid only when a previous strobe exists in the same measurement run.
module strobe_period_counter #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                strobe,
    input  logic                restart,
    output logic [PERIOD_W-1:0] since,
    output logic                new_valid,
    output logic [PERIOD_W-1:0] period
);

    logic [PERIOD_W-1:0] since_r;
    logic                have_prev_r;

    assign since     = since_r;
    assign new_valid = strobe & have_prev_r & ~restart;

    // Since-strobe counter (saturating), previous-strobe flag and period capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            since_r     <= {PERIOD_W{1'b0}};
            have_prev_r <= 1'b0;
            period      <= {PERIOD_W{1'b0}};
        end else if (clr) begin
            since_r     <= {PERIOD_W{1'b0}};
            have_prev_r <= 1'b0;
            period      <= {PERIOD_W{1'b0}};
        end else if (strobe) begin
            // Next cycle is already one cycle after this strobe.
            since_r     <= PERIOD_W'(1'b1);
            have_prev_r <= 1'b1;
            if (new_valid) begin
                period <= since_r;
            end else begin
                period <= period;
            end
        end else if (since_r != {PERIOD_W{1'b1}}) begin
            since_r <= since_r + PERIOD_W'(1'b1);
        end else begin
            since_r <= since_r;
        end
    end

endmodule

// File: rtl/sample_phase_tracker.sv
// Timestamps receiver frames against the output-frame phase and tracks lock.
// Optional feature macro: HOLD_REPEAT_EN (repeat held data while LOST instead of muting).
module sample_phase_tracker
    import audipus_rate_pkg::*;
#(
    parameter int FRAME_CYCLES   = 512,
    parameter int PERIOD_W       = 16,
    parameter int PERIOD_TOL     = 4,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MIN_PERIOD     = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    sample_phase_tracker_if.slave bus,
    output logic [PERIOD_W-1:0]   period,
    output logic                  locked,
    output logic                  lost,
    output logic                  overrun
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    track_state_t         state_r;
    logic [PHASE_W-1:0]   phase_r;
    logic [MATCH_W-1:0]   match_r;
    logic                 ref_ok_r;
    logic [PERIOD_W-1:0]  since_s;
    logic [PERIOD_W-1:0]  diff_s;
    logic                 new_valid_s;
    logic                 accept_s;
    logic                 restart_s;
    logic                 clr_s;
    logic                 consistent_s;
    logic                 timeout_s;
    logic                 synth_s;

    assign accept_s     = bus.in_strobe & run & (state_r != ST_IDLE);
    assign restart_s    = accept_s & (state_r == ST_LOST);
    assign clr_s        = ~run | (state_r == ST_IDLE);
    // Without a trusted reference (after start or an outlier) a period seeds the match run.
    assign consistent_s = ~ref_ok_r | (diff_s <= PERIOD_W'(PERIOD_TOL));
    assign timeout_s    = since_s >= PERIOD_W'(TIMEOUT_CYCLES);

    // Output-frame phase, pinned to zero while stopped so it stays aligned with the interpolator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= {PHASE_W{1'b0}};
        end else if (!run || phase_r == PHASE_W'(FRAME_CYCLES - 1)) begin
            phase_r <= {PHASE_W{1'b0}};
        end else begin
            phase_r <= phase_r + PHASE_W'(1'b1);
        end
    end

    strobe_period_counter #(
        .PERIOD_W (PERIOD_W)
    ) u_period (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr_s),
        .strobe    (accept_s),
        .restart   (restart_s),
        .since     (since_s),
        .new_valid (new_valid_s),
        .period    (period)
    );

    // Unsigned distance between the new period and the previous one.
    always_comb begin
        diff_s = {PERIOD_W{1'b0}};
        if (since_s >= period) begin
            diff_s = since_s - period;
        end else begin
            diff_s = period - since_s;
        end
    end

`ifdef HOLD_REPEAT_EN
    logic [PERIOD_W-1:0] rep_r;
    logic [PERIOD_W-1:0] rep_len_s;

    // Repeat interval: last valid period, or one output frame if none was measured.
    always_comb begin
        rep_len_s = period;
        if (period == {PERIOD_W{1'b0}}) begin
            rep_len_s = PERIOD_W'(FRAME_CYCLES);
        end else begin
            rep_len_s = period;
        end
    end

    assign synth_s = (state_r == ST_LOST) & ~accept_s & (rep_r == rep_len_s - PERIOD_W'(1'b1));

    // Cycles since LOST entry or the last synthetic strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_r <= {PERIOD_W{1'b0}};
        end else if (state_r != ST_LOST || accept_s || synth_s) begin
            rep_r <= {PERIOD_W{1'b0}};
        end else begin
            rep_r <= rep_r + PERIOD_W'(1'b1);
        end
    end
`else
    assign synth_s = 1'b0;
`endif

    // Tracking FSM with registered strobes, data, phase and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || !run) begin
            state_r            <= ST_IDLE;
            match_r            <= {MATCH_W{1'b0}};
            ref_ok_r           <= 1'b0;
            locked             <= 1'b0;
            lost               <= 1'b0;
            overrun            <= 1'b0;
            bus.l_din_en       <= 1'b0;
            bus.r_din_en       <= 1'b0;
            bus.l_data_out     <= {SAMPLE_W{1'b0}};
            bus.r_data_out     <= {SAMPLE_W{1'b0}};
            bus.sub_sample_cnt <= {PHASE_W{1'b0}};
        end else begin
            bus.l_din_en <= accept_s | synth_s;
            bus.r_din_en <= accept_s | synth_s;
            if (accept_s) begin
                bus.l_data_out     <= bus.l_in;
                bus.r_data_out     <= bus.r_in;
                bus.sub_sample_cnt <= phase_r;
            end else if (synth_s) begin
                bus.sub_sample_cnt <= phase_r;
            end else begin
                bus.sub_sample_cnt <= bus.sub_sample_cnt;
            end
            if (new_valid_s && since_s < PERIOD_W'(MIN_PERIOD)) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end

            case (state_r)
                ST_IDLE: begin
                    state_r  <= ST_ACQUIRE;
                    match_r  <= {MATCH_W{1'b0}};
                    ref_ok_r <= 1'b0;
                end
                ST_ACQUIRE, ST_TRACK: begin
                    if (new_valid_s && consistent_s) begin
                        ref_ok_r <= 1'b1;
                        if (state_r == ST_ACQUIRE && match_r == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_r <= ST_TRACK;
                            locked  <= 1'b1;
                            match_r <= {MATCH_W{1'b0}};
                        end else if (state_r == ST_ACQUIRE) begin
                            match_r <= match_r + MATCH_W'(1'b1);
                        end else begin
                            match_r <= match_r;
                        end
                    end else if (new_valid_s) begin
                        state_r  <= ST_ACQUIRE;
                        locked   <= 1'b0;
                        match_r  <= {MATCH_W{1'b0}};
                        ref_ok_r <= 1'b0;
                    end else if (!accept_s && timeout_s) begin
                        state_r <= ST_LOST;
                        locked  <= 1'b0;
                        lost    <= 1'b1;
`ifndef HOLD_REPEAT_EN
                        bus.l_data_out <= {SAMPLE_W{1'b0}};
                        bus.r_data_out <= {SAMPLE_W{1'b0}};
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOST: begin
                    if (accept_s) begin
                        state_r  <= ST_ACQUIRE;
                        lost     <= 1'b0;
                        match_r  <= {MATCH_W{1'b0}};
                        ref_ok_r <= 1'b0;
                    end else begin
                        state_r <= ST_LOST;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    locked  <= 1'b0;
                    lost    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_phase_tracker.sv
// Directed bench for sample_phase_tracker: lock, relock, timeout, phase capture,
// overrun, run-stop clearing and asynchronous reset.
module tb_sample_phase_tracker;
    import audipus_rate_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] period;
    logic        locked;
    logic        lost;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pulses = 0;

    sample_phase_tracker_if bus ();

    sample_phase_tracker dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .bus     (bus),
        .period  (period),
        .locked  (locked),
        .lost    (lost),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.l_din_en || bus.r_din_en) pulses++;
        end
    endtask

    // Drive one receiver frame; the phase expected is the count of run-high edges so far.
    task automatic send(input logic [23:0] l, input logic [23:0] r);
        int exp_ph;
        exp_ph        = cyc % 512;
        bus.in_strobe = 1'b1;
        bus.l_in      = l;
        bus.r_in      = r;
        tick();
        bus.in_strobe = 1'b0;
        check("l_din_en", 32'(bus.l_din_en), 32'd1);
        check("r_din_en", 32'(bus.r_din_en), 32'd1);
        check("l_data", 32'(bus.l_data_out), 32'(l));
        check("r_data", 32'(bus.r_data_out), 32'(r));
        check("phase", 32'(bus.sub_sample_cnt), 32'(exp_ph));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_l_en"}, 32'(bus.l_din_en), 32'd0);
        check({tag, "_r_en"}, 32'(bus.r_din_en), 32'd0);
        check({tag, "_l_data"}, 32'(bus.l_data_out), 32'd0);
        check({tag, "_r_data"}, 32'(bus.r_data_out), 32'd0);
        check({tag, "_phase"}, 32'(bus.sub_sample_cnt), 32'd0);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_lost"}, 32'(lost), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        run           = 1'b0;
        bus.in_strobe = 1'b0;
        bus.l_in      = 24'h0;
        bus.r_in      = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Lock on a 1024-cycle input period; locked after the 5th strobe.
        run = 1'b1;
        cyc = 0;
        idle(300);
        send(24'h123456, 24'hABCDEF);
        check("s1_period", 32'(period), 32'd0);
        check("s1_locked", 32'(locked), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            idle(1023);
            send(24'h123456, 24'hABCDEF);
            check("lock_period", 32'(period), 32'd1024);
            check("lock_locked", 32'(locked), (i == 5) ? 32'd1 : 32'd0);
        end
        check("gap_pulses", 32'(pulses), 32'd0);

        // One outlier period drops lock; four clean periods relock.
        idle(1029);
        send(24'h123456, 24'hABCDEF);
        check("outlier_period", 32'(period), 32'd1030);
        check("outlier_locked", 32'(locked), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            idle(1023);
            send(24'h123456, 24'hABCDEF);
            check("relock_period", 32'(period), 32'd1024);
            check("relock_locked", 32'(locked), (i == 4) ? 32'd1 : 32'd0);
        end
        check("no_overrun", 32'(overrun), 32'd0);

        // Strobes stop: LOST exactly when the since-strobe count reaches 4096.
        pulses = 0;
        idle(4095);
        check("pre_timeout_lost", 32'(lost), 32'd0);
        check("pre_timeout_locked", 32'(locked), 32'd1);
        check("pre_timeout_pulses", 32'(pulses), 32'd0);
        idle(1);
        check("timeout_lost", 32'(lost), 32'd1);
        check("timeout_locked", 32'(locked), 32'd0);
        pulses = 0;
        idle(1100);
`ifdef HOLD_REPEAT_EN
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_l_data", 32'(bus.l_data_out), 32'h123456);
`else
        check("mute_pulses", 32'(pulses), 32'd0);
        check("mute_l_data", 32'(bus.l_data_out), 32'd0);
        check("mute_r_data", 32'(bus.r_data_out), 32'd0);
`endif
        send(24'h0F0F0F, 24'h707070);
        check("recover_lost", 32'(lost), 32'd0);
        check("recover_locked", 32'(locked), 32'd0);

        // Phase 511 capture, then a back-to-back strobe sees the wrap to 0.
        idle(512);
        while (cyc % 512 != 511) tick();
        send(24'h000511, 24'h511000);
        check("p511_overrun", 32'(overrun), 32'd0);
        send(24'h000001, 24'h100000);
        check("wrap_phase", 32'(bus.sub_sample_cnt), 32'd0);
        check("b2b_period", 32'(period), 32'd1);
        check("b2b_overrun", 32'(overrun), 32'd1);

        run = 1'b0;
        tick();
        check_all_zero("stop");

        // Short period sets a sticky overrun.
        run = 1'b1;
        cyc = 0;
        idle(10);
        send(24'h111111, 24'h222222);
        idle(199);
        send(24'h333333, 24'h444444);
        check("short_period", 32'(period), 32'd200);
        check("short_overrun", 32'(overrun), 32'd1);
        idle(1023);
        send(24'h555555, 24'h666666);
        check("sticky_overrun", 32'(overrun), 32'd1);
        check("sticky_period", 32'(period), 32'd1024);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        run = 1'b0;
        repeat (2) @(posedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
